// File: rtl/data_sram_like_responder_if.sv
// Data-side SRAM-like bus: address-phase request/handshake plus in-order response channel.
interface data_sram_like_responder_if;
  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;

  modport master (
    output data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
           data_sram_addr, data_sram_wdata,
    input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
  );

  modport slave (
    input  data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
           data_sram_addr, data_sram_wdata,
    output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
  );
endinterface

// File: rtl/data_sram_like_responder.sv
// SRAM-like data slave: word memory committed at address acceptance, responses
// returned in order from a small aging queue after a fixed minimum latency.
module data_sram_like_responder #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned LAT        = 2,
  parameter int unsigned MAX_OUT    = 2
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         stall_en,
  data_sram_like_responder_if.slave    bus
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);
  localparam int unsigned AGE_W = 4;
  localparam logic [AGE_W-1:0] AGE_DONE = AGE_W'(LAT);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_OUT);

  logic [31:0]      mem_q [DEPTH];
  logic [31:0]      data_q [MAX_OUT];
  logic [AGE_W-1:0] age_q [MAX_OUT];
  logic [AGE_W-1:0] age_d [MAX_OUT];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             data_ok_q, data_ok_d;
  logic [31:0]      rdata_q, rdata_d;

  logic                  acc;
  logic                  pop;
  logic [DEPTH_LOG2-1:0] widx;
  logic [31:0]           enq_data;
  logic                  unused_bits;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUT - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Acceptance depends only on registered occupancy, never on this cycle's pop.
  assign bus.data_sram_addr_ok = resetn & bus.data_sram_req & ~stall_en & (cnt_q != CNT_FULL);
  assign acc      = bus.data_sram_req & bus.data_sram_addr_ok;
  assign pop      = data_ok_q;
  assign widx     = bus.data_sram_addr[DEPTH_LOG2+1:2];
  assign enq_data = bus.data_sram_wr ? 32'h0 : mem_q[widx];

  assign unused_bits = ^{bus.data_sram_size, bus.data_sram_addr[31:DEPTH_LOG2+2],
                         bus.data_sram_addr[1:0]};

  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    cnt_d     = cnt_q;
    data_ok_d = 1'b0;
    rdata_d   = 32'h0;
    for (int i = 0; i < int'(MAX_OUT); i++) begin
      age_d[i] = (age_q[i] == AGE_DONE) ? age_q[i] : age_q[i] + AGE_W'(1);
    end

    if (acc) begin
      age_d[tail_q] = AGE_W'(1);
      tail_d        = ptr_inc(tail_q);
    end
    if (pop) begin
      head_d = ptr_inc(head_q);
    end
    case ({acc, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase

    // Head equal to the slot being filled means the new entry is the only one (LAT == 1 bypass).
    data_ok_d = (cnt_d != '0) && (age_d[head_d] == AGE_DONE);
    if (data_ok_d) begin
      rdata_d = (acc && (head_d == tail_q)) ? enq_data : data_q[head_d];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q    <= '0;
      tail_q    <= '0;
      cnt_q     <= '0;
      data_ok_q <= 1'b0;
      rdata_q   <= 32'h0;
      for (int i = 0; i < int'(MAX_OUT); i++) begin
        age_q[i] <= '0;
      end
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      cnt_q     <= cnt_d;
      data_ok_q <= data_ok_d;
      rdata_q   <= rdata_d;
      for (int i = 0; i < int'(MAX_OUT); i++) begin
        age_q[i] <= age_d[i];
      end
    end
  end

  // Payload storage carries no reset; validity is tracked by pointers and count.
  always_ff @(posedge clk) begin
    if (acc) begin
      data_q[tail_q] <= enq_data;
    end
  end

  always_ff @(posedge clk) begin
    if (acc && bus.data_sram_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.data_sram_wstrb[b]) begin
          mem_q[widx][8*b +: 8] <= bus.data_sram_wdata[8*b +: 8];
        end
      end
    end
  end

  assign bus.data_sram_data_ok = data_ok_q;
  assign bus.data_sram_rdata   = rdata_q;

endmodule

// File: tb/tb_data_sram_like_responder.sv
// Scoreboard bench: each accepted request pushes its expected data and response cycle.
module tb_data_sram_like_responder;

  localparam int unsigned DEPTH_LOG2 = 10;
  localparam int unsigned LAT        = 2;
  localparam int unsigned MAX_OUT    = 2;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic stall_en = 1'b0;

  data_sram_like_responder_if bus ();

  data_sram_like_responder #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .LAT        (LAT),
    .MAX_OUT    (MAX_OUT)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .stall_en (stall_en),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  exp_t                  sb[$];
  exp_t                  mon_e;
  logic [31:0]           mdl [1 << DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] mon_idx;
  int                    cyc = 0;
  int                    last_sched = 0;
  int                    n_checks = 0;
  int                    n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Response checking first, then record any acceptance seen this cycle.
  always @(negedge clk) begin
    if (bus.data_sram_data_ok) begin
      if (sb.size() == 0) begin
        chk("spurious_data_ok", 32'(1), 32'(0));
      end else begin
        mon_e = sb.pop_front();
        chk("rdata", bus.data_sram_rdata, mon_e.data);
        chk("resp_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
    end else begin
      chk("idle_rdata", bus.data_sram_rdata, 32'h0);
    end

    if (bus.data_sram_req && bus.data_sram_addr_ok) begin
      mon_idx     = bus.data_sram_addr[DEPTH_LOG2+1:2];
      mon_e.cyc   = ((cyc + int'(LAT)) > (last_sched + 1)) ? (cyc + int'(LAT)) : (last_sched + 1);
      last_sched  = mon_e.cyc;
      if (bus.data_sram_wr) begin
        mon_e.data = 32'h0;
        for (int b = 0; b < 4; b++) begin
          if (bus.data_sram_wstrb[b]) mdl[mon_idx][8*b +: 8] = bus.data_sram_wdata[8*b +: 8];
        end
      end else begin
        mon_e.data = mdl[mon_idx];
      end
      sb.push_back(mon_e);
    end
  end

  // Called at posedge+1; returns after acceptance, at the following posedge+1.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [3:0] strb,
                       input logic [31:0] wdata, output int waits);
    waits = 0;
    bus.data_sram_req   = 1'b1;
    bus.data_sram_wr    = wr;
    bus.data_sram_size  = 2'd2;
    bus.data_sram_wstrb = strb;
    bus.data_sram_addr  = addr;
    bus.data_sram_wdata = wdata;
    do begin
      @(negedge clk);
      waits++;
    end while (!bus.data_sram_addr_ok && waits < 50);
    if (!bus.data_sram_addr_ok) chk("accept_timeout", 32'(0), 32'(1));
    @(posedge clk);
    #1;
    bus.data_sram_req = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("drain", 32'(sb.size()), 32'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w;
    bus.data_sram_req   = 1'b0;
    bus.data_sram_wr    = 1'b0;
    bus.data_sram_size  = 2'd0;
    bus.data_sram_wstrb = 4'h0;
    bus.data_sram_addr  = 32'h0;
    bus.data_sram_wdata = 32'h0;

    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    @(negedge clk);
    chk("reset_addr_ok", 32'(bus.data_sram_addr_ok), 32'(0));
    chk("reset_data_ok", 32'(bus.data_sram_data_ok), 32'(0));
    @(posedge clk);
    #1;

    // Full write, read back, then a single-lane update
    issue(1'b1, 32'h10, 4'hF, 32'h11223344, w);
    issue(1'b0, 32'h10, 4'h0, 32'h0, w);
    issue(1'b1, 32'h12, 4'h4, 32'h000000AA, w);
    issue(1'b0, 32'h10, 4'h0, 32'h0, w);
    issue(1'b1, 32'h14, 4'h0, 32'hFFFFFFFF, w);
    drain();

    // Back-to-back reads fill the queue; third request waits one cycle
    issue(1'b1, 32'h0, 4'hF, 32'hA5A50001, w);
    issue(1'b1, 32'h4, 4'hF, 32'h5A5A0002, w);
    drain();
    issue(1'b0, 32'h0, 4'h0, 32'h0, w);
    chk("b2b_first_wait", 32'(w), 32'(1));
    issue(1'b0, 32'h4, 4'h0, 32'h0, w);
    chk("b2b_second_wait", 32'(w), 32'(1));
    issue(1'b0, 32'h10, 4'h0, 32'h0, w);
    chk("refill_wait", 32'(w), 32'(2));
    drain();

    // Address-phase stall with request held
    bus.data_sram_req  = 1'b1;
    bus.data_sram_wr   = 1'b0;
    bus.data_sram_addr = 32'h4;
    stall_en = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stall_addr_ok", 32'(bus.data_sram_addr_ok), 32'(0));
    end
    @(posedge clk);
    #1;
    stall_en = 1'b0;
    @(negedge clk);
    chk("unstall_addr_ok", 32'(bus.data_sram_addr_ok), 32'(1));
    @(posedge clk);
    #1;
    bus.data_sram_req = 1'b0;
    drain();

    // Aliasing: upper address bits are ignored
    issue(1'b1, 32'h1000, 4'hF, 32'hDEADBEEF, w);
    issue(1'b0, 32'h0, 4'h0, 32'h0, w);
    drain();

    // Random traffic over a preloaded window
    for (int i = 1; i < 16; i++) issue(1'b1, 32'(i * 4), 4'hF, $urandom, w);
    for (int i = 0; i < 30; i++) begin
      int g = $urandom_range(0, 2);
      if (g > 0) begin
        repeat (g) @(posedge clk);
        #1;
      end
      issue(1'($urandom_range(0, 1)), 32'($urandom_range(0, 15) * 4), 4'($urandom),
            $urandom, w);
    end
    drain();

    // Reset with two reads outstanding
    issue(1'b0, 32'h10, 4'h0, 32'h0, w);
    issue(1'b0, 32'h4, 4'h0, 32'h0, w);
    resetn = 1'b0;
    sb.delete();
    last_sched = 0;
    bus.data_sram_req  = 1'b1;
    bus.data_sram_addr = 32'h10;
    @(negedge clk);
    chk("rst_addr_ok", 32'(bus.data_sram_addr_ok), 32'(0));
    chk("rst_data_ok", 32'(bus.data_sram_data_ok), 32'(0));
    @(posedge clk);
    #1;
    resetn = 1'b1;
    bus.data_sram_req = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    issue(1'b0, 32'h10, 4'h0, 32'h0, w);
    chk("post_rst_wait", 32'(w), 32'(1));
    issue(1'b0, 32'h0, 4'h0, 32'h0, w);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
